// File: rtl/riscv_instr_mem_responder_pkg.sv
// Shared widths, grant-FSM state encoding and payload types for the
// instruction-fetch responder.
package riscv_instr_mem_responder_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned WAIT_W       = 4;
    localparam int unsigned DLY_W        = 2;
    localparam int unsigned OUTST_W      = 3;
    localparam int unsigned FR_STATE_W   = 2;

    // Grant FSM states (fetch_resp_state_e)
    localparam logic [FR_STATE_W-1:0] FR_IDLE  = 2'd0;
    localparam logic [FR_STATE_W-1:0] FR_WAIT  = 2'd1;
    localparam logic [FR_STATE_W-1:0] FR_READY = 2'd2;

    // Information captured at grant time for the response queue
    typedef struct packed {
        logic             err;
        logic [DLY_W-1:0] dly;
    } fetch_resp_push_t;

endpackage

// File: rtl/riscv_instr_resp_queue.sv
// In-order response queue: entry pushed at grant, SRAM data written one
// cycle later, head retires once its data is present and its delay expired.
module riscv_instr_resp_queue
    import riscv_instr_mem_responder_pkg::*;
#(
    parameter int unsigned RDATA_WIDTH = 32,
    parameter int unsigned DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   push_err,
    input  logic [DLY_W-1:0]       push_dly,
    input  logic [RDATA_WIDTH-1:0] wdata,
    output logic                   head_valid_c,
    output logic [RDATA_WIDTH-1:0] head_rdata_c,
    output logic                   head_err_c,
    output logic [OUTST_W-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SLOTS = 1 << PTR_W;

    typedef struct packed {
        logic [RDATA_WIDTH-1:0] rdata;
        logic                   err;
        logic [DLY_W-1:0]       cnt;
        logic                   data_ok;
    } fetch_resp_entry_t;

    fetch_resp_entry_t  entry_q [SLOTS];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [PTR_W-1:0]   wr_idx_q;
    logic               wr_pend_q;
    logic [OUTST_W-1:0] count_q;
    logic               head_fill_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Head may retire in the same cycle its SRAM data arrives (bypass)
    always_comb begin
        head_fill_c  = wr_pend_q && (wr_idx_q == head_q);
        head_valid_c = (count_q != '0) && (entry_q[head_q].cnt == '0) &&
                       (entry_q[head_q].data_ok || head_fill_c);
        head_rdata_c = entry_q[head_q].data_ok ? entry_q[head_q].rdata : wdata;
        head_err_c   = entry_q[head_q].err;
    end

    // Push overrides the data write when a slot is retired and reused at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) entry_q[i] <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            wr_idx_q  <= '0;
            wr_pend_q <= 1'b0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (entry_q[i].cnt != '0) entry_q[i].cnt <= entry_q[i].cnt - DLY_W'(1);
            end
            if (wr_pend_q) begin
                entry_q[wr_idx_q].rdata   <= wdata;
                entry_q[wr_idx_q].data_ok <= 1'b1;
            end
            if (push) begin
                entry_q[tail_q] <= fetch_resp_entry_t'{rdata: '0, err: push_err,
                                                       cnt: push_dly, data_ok: push_err};
                tail_q <= ptr_inc(tail_q);
            end
            wr_pend_q <= push && !push_err;
            wr_idx_q  <= tail_q;
            if (head_valid_c) head_q <= ptr_inc(head_q);
            count_q <= count_q + OUTST_W'(push) - OUTST_W'(head_valid_c);
        end
    end

    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_q == OUTST_W'(DEPTH)) && !head_valid_c));

endmodule

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch responder: grant FSM with programmable wait states,
// address window check and SRAM drive, in front of an in-order response queue.
module riscv_instr_mem_responder
    import riscv_instr_mem_responder_pkg::*;
#(
    parameter int unsigned             RDATA_WIDTH     = 32,
    parameter int unsigned             MEM_ADDR_W      = 12,
    parameter logic [FETCH_ADDR_W-1:0] BASE_ADDR       = 32'h1C008000,
    parameter int unsigned             MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_req_i,
    input  logic [FETCH_ADDR_W-1:0] instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [RDATA_WIDTH-1:0]  instr_rdata_o,
    output logic                    instr_err_o,
    input  logic [WAIT_W-1:0]       wait_states_i,
    input  logic [DLY_W-1:0]        rvalid_delay_i,
    output logic                    mem_req_o,
    output logic [MEM_ADDR_W-1:0]   mem_addr_o,
    input  logic [RDATA_WIDTH-1:0]  mem_rdata_i,
    output logic [OUTST_W-1:0]      outstanding_o
);

    localparam int unsigned             WORD_BYTES = RDATA_WIDTH / 8;
    localparam int unsigned             OFF_W      = $clog2(WORD_BYTES);
    localparam logic [FETCH_ADDR_W-1:0] MEM_BYTES  = FETCH_ADDR_W'(WORD_BYTES << MEM_ADDR_W);

    logic [FR_STATE_W-1:0]   state_q, state_n;
    logic [WAIT_W-1:0]       wait_q, wait_n;
    logic                    fsm_gnt_c;
    logic                    grant_c;
    logic                    space_c;
    logic                    in_range_c;
    logic [FETCH_ADDR_W-1:0] offset_c;
    fetch_resp_push_t        push_info_c;

    logic                    retire_c;
    logic [RDATA_WIDTH-1:0]  head_rdata_c;
    logic                    head_err_c;
    logic [OUTST_W-1:0]      count;
    logic [RDATA_WIDTH-1:0]  last_rdata_q;
    logic                    last_err_q;

    // A response retiring this cycle frees its slot for a same-cycle grant
    assign space_c = (count < OUTST_W'(MAX_OUTSTANDING)) || retire_c;

    // Address window check; word index drops the sub-word byte bits
    assign offset_c   = instr_addr_i - BASE_ADDR;
    assign in_range_c = (instr_addr_i >= BASE_ADDR) && (offset_c < MEM_BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FR_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_n;
            wait_q  <= wait_n;
        end
    end

    // Grant FSM; the wait count is loaded once per request and counts down
    always_comb begin
        state_n   = state_q;
        wait_n    = wait_q;
        fsm_gnt_c = 1'b0;
        case (state_q)
            FR_IDLE: begin
                if (instr_req_i) begin
                    if (wait_states_i == '0) begin
                        fsm_gnt_c = space_c;
                    end else if (wait_states_i == WAIT_W'(1)) begin
                        state_n = FR_READY;
                    end else begin
                        wait_n  = wait_states_i;
                        state_n = FR_WAIT;
                    end
                end
            end
            FR_WAIT: begin
                if (!instr_req_i) begin
                    state_n = FR_IDLE;
                end else begin
                    wait_n = wait_q - WAIT_W'(1);
                    if (wait_q == WAIT_W'(2)) state_n = FR_READY;
                end
            end
            FR_READY: begin
                if (!instr_req_i) begin
                    state_n = FR_IDLE;
                end else if (space_c) begin
                    fsm_gnt_c = 1'b1;
                    state_n   = FR_IDLE;
                end
            end
            default: state_n = FR_IDLE;
        endcase
    end

    // No grant can be recorded while reset holds the queue empty
    assign grant_c     = fsm_gnt_c & rst_n;
    assign instr_gnt_o = grant_c;
    assign mem_req_o   = grant_c & in_range_c;
    assign mem_addr_o  = mem_req_o ? offset_c[OFF_W +: MEM_ADDR_W] : '0;

    always_comb begin
        push_info_c     = '0;
        push_info_c.err = !in_range_c;
        push_info_c.dly = rvalid_delay_i;
    end

    riscv_instr_resp_queue #(
        .RDATA_WIDTH (RDATA_WIDTH),
        .DEPTH       (MAX_OUTSTANDING)
    ) u_resp_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (grant_c),
        .push_err     (push_info_c.err),
        .push_dly     (push_info_c.dly),
        .wdata        (mem_rdata_i),
        .head_valid_c (retire_c),
        .head_rdata_c (head_rdata_c),
        .head_err_c   (head_err_c),
        .count        (count)
    );

    // Response data/err hold their last retired values between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rdata_q <= '0;
            last_err_q   <= 1'b0;
        end else if (retire_c) begin
            last_rdata_q <= head_rdata_c;
            last_err_q   <= head_err_c;
        end
    end

    assign instr_rvalid_o = retire_c;
    assign instr_rdata_o  = retire_c ? head_rdata_c : last_rdata_q;
    assign instr_err_o    = retire_c ? head_err_c : last_err_q;
    assign outstanding_o  = count;

    a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
        instr_gnt_o |-> instr_req_i);
    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid_o |-> (outstanding_o != '0));
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_o <= OUTST_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Directed bench for riscv_instr_mem_responder with a transaction-level
// response model checked every cycle plus hand-computed spot checks.
module tb_riscv_instr_mem_responder;

    localparam logic [31:0] BASE = 32'h1C008000;
    localparam int          MAXO = 2;
    localparam int          WIN  = 16384;

    logic        clk;
    logic        rst_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic [3:0]  wait_states_i;
    logic [1:0]  rvalid_delay_i;
    logic        mem_req_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic [2:0]  outstanding_o;

    riscv_instr_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .wait_states_i  (wait_states_i),
        .rvalid_delay_i (rvalid_delay_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .outstanding_o  (outstanding_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: data one cycle after the read, garbage otherwise
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
        else           mem_rdata_i <= 32'hBAD0_0000 ^ 32'(cyc);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: each grant yields one response, released no earlier
    // than grant+1+delay and strictly after the previous response.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        mq[$];
    exp_t        m_e;
    int          m_out = 0;
    int          last_due = 0;
    logic [31:0] m_last_rd = '0;
    logic        m_last_err = 1'b0;
    logic        m_exp_v;
    logic        m_inr;
    logic [11:0] m_idx;

    function automatic logic in_window(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + 33'(WIN)));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_out      = 0;
            last_due   = 0;
            m_last_rd  = '0;
            m_last_err = 1'b0;
        end else begin
            chk("outstanding", 128'(outstanding_o), 128'(m_out));
            m_exp_v = (mq.size() > 0) && (mq[0].due == cyc);
            chk("rvalid", 128'(instr_rvalid_o), 128'(m_exp_v));
            if (m_exp_v) begin
                m_last_rd  = mq[0].rdata;
                m_last_err = mq[0].err;
                void'(mq.pop_front());
                m_out--;
            end
            chk("rdata", 128'(instr_rdata_o), 128'(m_last_rd));
            chk("err", 128'(instr_err_o), 128'(m_last_err));
            if (instr_gnt_o) begin
                chk("gnt_without_req", 128'(instr_req_i), 128'(1));
                chk("gnt_without_space", 128'(m_out < MAXO), 128'(1));
                m_inr = in_window(instr_addr_i);
                m_idx = 12'((instr_addr_i - BASE) / 4);
                chk("mem_req_at_gnt", 128'(mem_req_o), 128'(m_inr));
                if (m_inr) chk("mem_addr", 128'(mem_addr_o), 128'(m_idx));
                m_e.rdata = m_inr ? mem[m_idx] : 32'h0;
                m_e.err   = !m_inr;
                m_e.due   = (cyc + 1 + int'(rvalid_delay_i) > last_due + 1) ?
                            cyc + 1 + int'(rvalid_delay_i) : last_due + 1;
                last_due  = m_e.due;
                mq.push_back(m_e);
                m_out++;
            end else begin
                chk("mem_req_no_gnt", 128'(mem_req_o), 128'(0));
            end
        end
    end

    logic        s_gnt, s_rv, s_err, s_mreq;
    logic [31:0] s_rd;
    logic [11:0] s_maddr;

    // Drive one cycle of inputs, sample outputs at the falling edge
    task automatic step(input logic req, input logic [31:0] a, input logic [3:0] ws,
                        input logic [1:0] dly);
        instr_req_i    = req;
        instr_addr_i   = a;
        wait_states_i  = ws;
        rvalid_delay_i = dly;
        @(negedge clk);
        s_gnt   = instr_gnt_o;
        s_rv    = instr_rvalid_o;
        s_rd    = instr_rdata_o;
        s_err   = instr_err_o;
        s_mreq  = mem_req_o;
        s_maddr = mem_addr_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'd0, 2'd0);
    endtask

    logic [7:0]  gp;
    logic [7:0]  vp;
    logic [31:0] rd4, rd5;
    int          waited;

    logic [31:0] bnd_addr [5] = '{BASE + 32'h3FFC, BASE + 32'h4000, BASE - 32'd4,
                                  BASE + 32'h13, 32'hFFFF_FFFC};
    logic        bnd_in   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] bnd_idx  [5] = '{12'd4095, 12'd0, 12'd0, 12'd4, 12'd0};

    logic [31:0] bu_addr [6] = '{BASE + 32'h40, BASE + 32'h44, 32'h0000_1000,
                                 BASE + 32'h48, BASE + 32'h4C, BASE + 32'h50};
    logic [3:0]  bu_ws   [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd5, 4'd0};
    logic [1:0]  bu_dly  [6] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};

    initial begin
        rst_n          = 1'b0;
        instr_req_i    = 1'b0;
        instr_addr_i   = '0;
        wait_states_i  = '0;
        rvalid_delay_i = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E37_79B9;
        mem[4]    = 32'hDEADBEEF;
        mem[10]   = 32'h1111_AAAA;
        mem[11]   = 32'h2222_BBBB;
        mem[4095] = 32'hCAFE_F00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 128'(instr_gnt_o), 128'(0));
        chk("reset_rvalid", 128'(instr_rvalid_o), 128'(0));
        chk("reset_rdata", 128'(instr_rdata_o), 128'(0));
        chk("reset_outstanding", 128'(outstanding_o), 128'(0));
        chk("reset_mem_req", 128'(mem_req_o), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero-wait, zero-delay fetch of word 4
        step(1'b1, 32'h1C008010, 4'd0, 2'd0);
        chk("t1_gnt", 128'(s_gnt), 128'(1));
        chk("t1_mem_req", 128'(s_mreq), 128'(1));
        chk("t1_mem_addr", 128'(s_maddr), 128'(4));
        step(1'b0, 32'h0, 4'd0, 2'd0);
        chk("t1_rvalid", 128'(s_rv), 128'(1));
        chk("t1_rdata", 128'(s_rd), 128'(32'hDEADBEEF));
        chk("t1_err", 128'(s_err), 128'(0));
        idle(2);

        // Three wait states, request held across two grants
        gp = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, BASE + 32'h20, 4'd3, 2'd0);
            gp[i] = s_gnt;
        end
        chk("t2_gnt_pattern", 128'(gp), 128'(8'b1000_1000));
        idle(3);

        // Request drop during WAIT restarts the count
        gp = '0;
        for (int i = 0; i < 5; i++) begin
            step(i != 1, BASE + 32'h24, 4'd2, 2'd0);
            gp[i] = s_gnt;
        end
        chk("t2b_gnt_pattern", 128'(gp), 128'(5'b10000));
        idle(3);

        // Out-of-range fetch
        step(1'b1, 32'h0000_0000, 4'd0, 2'd0);
        chk("t3_gnt", 128'(s_gnt), 128'(1));
        chk("t3_mem_req", 128'(s_mreq), 128'(0));
        step(1'b0, 32'h0, 4'd0, 2'd0);
        chk("t3_rvalid", 128'(s_rv), 128'(1));
        chk("t3_err", 128'(s_err), 128'(1));
        chk("t3_rdata", 128'(s_rd), 128'(0));
        idle(2);

        // Outstanding limit with response delay 3
        gp = '0;
        vp = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, BASE + 32'h28, 4'd0, 2'd3);
            gp[i] = s_gnt;
            vp[i] = s_rv;
        end
        chk("t4_gnt_pattern", 128'(gp[5:0]), 128'(6'b110011));
        chk("t4_rvalid_pattern", 128'(vp[5:0]), 128'(6'b110000));
        idle(10);

        // Slow head blocks a fast younger entry whose data must survive
        vp  = '0;
        rd4 = '0;
        rd5 = '0;
        step(1'b1, BASE + 32'h28, 4'd0, 2'd3);
        vp[0] = s_rv;
        step(1'b1, BASE + 32'h2C, 4'd0, 2'd0);
        vp[1] = s_rv;
        for (int i = 2; i < 7; i++) begin
            step(1'b0, 32'h0, 4'd0, 2'd0);
            vp[i] = s_rv;
            if (i == 4) rd4 = s_rd;
            if (i == 5) rd5 = s_rd;
        end
        chk("t5_rvalid_pattern", 128'(vp[6:0]), 128'(7'b0110000));
        chk("t5_rdata_a", 128'(rd4), 128'(32'h1111_AAAA));
        chk("t5_rdata_b", 128'(rd5), 128'(32'h2222_BBBB));
        idle(2);

        // Address window boundaries and ignored low bits
        for (int k = 0; k < 5; k++) begin
            step(1'b1, bnd_addr[k], 4'd0, 2'd0);
            chk("bnd_mem_req", 128'(s_mreq), 128'(bnd_in[k]));
            if (bnd_in[k]) chk("bnd_mem_addr", 128'(s_maddr), 128'(bnd_idx[k]));
            step(1'b0, 32'h0, 4'd0, 2'd0);
            chk("bnd_err", 128'(s_err), 128'(!bnd_in[k]));
        end
        idle(2);

        // Mixed wait states and delays, request held until granted
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            do begin
                step(1'b1, bu_addr[k], bu_ws[k], bu_dly[k]);
                waited++;
            end while (!s_gnt && waited < 20);
            if (!s_gnt) chk("burst_gnt_timeout", 128'(0), 128'(1));
        end
        idle(12);

        // Reset with two responses pending
        step(1'b1, BASE + 32'h28, 4'd0, 2'd3);
        step(1'b1, BASE + 32'h2C, 4'd0, 2'd3);
        instr_req_i = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("t6_rvalid", 128'(instr_rvalid_o), 128'(0));
        chk("t6_outstanding", 128'(outstanding_o), 128'(0));
        chk("t6_gnt", 128'(instr_gnt_o), 128'(0));
        chk("t6_rdata", 128'(instr_rdata_o), 128'(0));
        chk("t6_err", 128'(instr_err_o), 128'(0));
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        vp = '0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 4'd0, 2'd0);
            vp[i] = s_rv;
        end
        chk("t6_no_rvalid_after_reset", 128'(vp), 128'(0));
        step(1'b1, 32'h1C008010, 4'd0, 2'd0);
        step(1'b0, 32'h0, 4'd0, 2'd0);
        chk("t6_new_rvalid", 128'(s_rv), 128'(1));
        chk("t6_new_rdata", 128'(s_rd), 128'(32'hDEADBEEF));
        idle(4);

        chk("model_drained", 128'(mq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
